// File: rtl/count_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : count_reg_if
//  Brief    : CPU-side register interface of one counter channel. Decodes
//             control words, assembles 8/16-bit count values for the counting
//             element, and serves latched or live count reads byte by byte.
//  Revision : 1.0 - initial release
// ============================================================================
module count_reg_if (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic        rd,
   input  logic [1:0]  addr,
   input  logic [7:0]  din,
   input  logic [15:0] cur_count,
   output logic [7:0]  dout,
   output logic [7:0]  msb,
   output logic [7:0]  lsb,
   output logic        load,
   output logic [2:0]  mode,
   output logic        bcd,
   output logic        null_count
);

   localparam logic [1:0] c_ADDR_COUNT = 2'b00;
   localparam logic [1:0] c_ADDR_CTRL  = 2'b11;
   localparam logic [1:0] c_RW_LATCH   = 2'b00;
   localparam logic [1:0] c_RW_LSB     = 2'b01;
   localparam logic [1:0] c_RW_MSB     = 2'b10;
   localparam logic [1:0] c_RW_WORD    = 2'b11;

   // Architectural state (current / next)
   logic        configured_q, configured_d;
   logic [1:0]  rw_q,         rw_d;
   logic [2:0]  mode_q,       mode_d;
   logic        bcd_q,        bcd_d;
   logic        null_q,       null_d;
   logic        wptr_q,       wptr_d;   // 0 = next write is low byte
   logic        rptr_q,       rptr_d;   // 0 = next read is low byte
   logic        latched_q,    latched_d;
   logic [15:0] latch_q,      latch_d;
   logic [7:0]  pending_q,    pending_d;
   logic [7:0]  msb_q,        msb_d;
   logic [7:0]  lsb_q,        lsb_d;
   logic        load_q,       load_d;
   logic [7:0]  dout_q,       dout_d;

   // Access decode; a write always wins over a simultaneous read
   logic        w_wr_ctrl;
   logic        w_wr_cnt;
   logic        w_rd_cnt;
   logic [1:0]  w_sc;
   logic [1:0]  w_rw;
   logic [2:0]  w_m;
   logic [15:0] w_rd_src;
   logic        w_rd_hi;
   logic        w_rd_final;

   assign w_wr_ctrl  = wr && (addr == c_ADDR_CTRL);
   assign w_wr_cnt   = wr && (addr == c_ADDR_COUNT);
   assign w_rd_cnt   = !wr && rd && (addr == c_ADDR_COUNT);
   assign w_sc       = din[7:6];
   assign w_rw       = din[5:4];
   assign w_m        = din[3:1];
   assign w_rd_src   = latched_q ? latch_q : cur_count;
   assign w_rd_hi    = (rw_q == c_RW_MSB) || ((rw_q == c_RW_WORD) && rptr_q);
   // The last byte of a complete read: single-byte modes always, word mode on MSB
   assign w_rd_final = (rw_q != c_RW_WORD) || rptr_q;

   // Next-state decode for control words, count writes and count reads
   always_comb begin
      configured_d = configured_q;
      rw_d         = rw_q;
      mode_d       = mode_q;
      bcd_d        = bcd_q;
      null_d       = null_q;
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      latched_d    = latched_q;
      latch_d      = latch_q;
      pending_d    = pending_q;
      msb_d        = msb_q;
      lsb_d        = lsb_q;
      load_d       = 1'b0;
      dout_d       = dout_q;

      if (w_wr_ctrl) begin
         if (w_sc == 2'b00) begin
            if (w_rw == c_RW_LATCH) begin
               // Counter-latch command: the first capture sticks until read out
               if (!latched_q) begin
                  latch_d   = cur_count;
                  latched_d = 1'b1;
               end
            end else begin
               rw_d         = w_rw;
               // Modes 6 and 7 alias to modes 2 and 3
               mode_d       = w_m[1] ? {1'b0, w_m[1:0]} : w_m;
               bcd_d        = din[0];
               configured_d = 1'b1;
               null_d       = 1'b1;
               wptr_d       = 1'b0;
               rptr_d       = 1'b0;
               latched_d    = 1'b0;
               pending_d    = 8'h00;
            end
         end
      end else if (w_wr_cnt) begin
         if (configured_q) begin
            case (rw_q)
               c_RW_LSB: begin
                  lsb_d  = din;
                  msb_d  = 8'h00;
                  load_d = 1'b1;
                  null_d = 1'b0;
               end
               c_RW_MSB: begin
                  msb_d  = din;
                  lsb_d  = 8'h00;
                  load_d = 1'b1;
                  null_d = 1'b0;
               end
               c_RW_WORD: begin
                  if (!wptr_q) begin
                     pending_d = din;
                     wptr_d    = 1'b1;
                  end else begin
                     lsb_d  = pending_q;
                     msb_d  = din;
                     load_d = 1'b1;
                     null_d = 1'b0;
                     wptr_d = 1'b0;
                  end
               end
               default: begin
                  // Unreachable once configured (RW=00 never stored)
               end
            endcase
         end
      end else if (w_rd_cnt) begin
         if (configured_q) begin
            dout_d = w_rd_hi ? w_rd_src[15:8] : w_rd_src[7:0];
            if (rw_q == c_RW_WORD) begin
               rptr_d = !rptr_q;
            end
            if (w_rd_final) begin
               latched_d = 1'b0;
               rptr_d    = 1'b0;
            end
         end else begin
            dout_d = 8'h00;
         end
      end
   end

   // State registers; reset discards pending bytes and latches immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         configured_q <= 1'b0;
         rw_q         <= 2'b00;
         mode_q       <= 3'b000;
         bcd_q        <= 1'b0;
         null_q       <= 1'b0;
         wptr_q       <= 1'b0;
         rptr_q       <= 1'b0;
         latched_q    <= 1'b0;
         latch_q      <= 16'h0000;
         pending_q    <= 8'h00;
         msb_q        <= 8'h00;
         lsb_q        <= 8'h00;
         load_q       <= 1'b0;
         dout_q       <= 8'h00;
      end else begin
         configured_q <= configured_d;
         rw_q         <= rw_d;
         mode_q       <= mode_d;
         bcd_q        <= bcd_d;
         null_q       <= null_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         latched_q    <= latched_d;
         latch_q      <= latch_d;
         pending_q    <= pending_d;
         msb_q        <= msb_d;
         lsb_q        <= lsb_d;
         load_q       <= load_d;
         dout_q       <= dout_d;
      end
   end

   assign dout       = dout_q;
   assign msb        = msb_q;
   assign lsb        = lsb_q;
   assign load       = load_q;
   assign mode       = mode_q;
   assign bcd        = bcd_q;
   assign null_count = null_q;

endmodule
`default_nettype wire

// File: doc/count_reg_if.md
COUNT_REG_IF -- requirements
Module: count_reg_if

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; ports clk and rst; all state updates on rising clk.
REQ-002 Port list (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  async active-high reset
- wr  in  1  single-cycle bus write strobe
- rd  in  1  single-cycle bus read strobe
- addr  in  2  00 = counter 0 data, 11 = control word, 01/10 ignored
- din  in  8  CPU write data
- cur_count  in  16  live count from the counting element
- dout  out  8  CPU read data, registered
- msb  out  8  count high byte to the counting element
- lsb  out  8  count low byte to the counting element
- load  out  1  one-cycle pulse when a complete new count is presented on msb/lsb
- mode  out  3  programmed mode
- bcd  out  1  programmed BCD flag
- null_count  out  1  high from control-word write until the next load pulse

Function
REQ-003 Control word (addr=11, wr=1): fields SC=din[7:6], RW=din[5:4], M=din[3:1], BCD=din[0]; a control word with SC!=00 SHALL be ignored entirely.
REQ-004 For SC=00 with RW!=00: store RW, store mode=M with M[2] forced to 0 when M[1]=1 (110->010, 111->011), store bcd, set configured=1, set null_count=1, reset the write and read byte pointers to LSB, and clear any held latch.
REQ-005 For SC=00 with RW=00 (latch command): if no latch is held, capture cur_count into the 16-bit latch in that cycle and set latched=1; if already latched, ignore; RW, mode, bcd, and the pointers SHALL remain unchanged.
REQ-006 A count write (addr=00, wr=1) with configured=0 SHALL be ignored.
REQ-007 With RW=01: lsb<=din, msb<=0, load pulses on the next cycle.
REQ-008 With RW=10: msb<=din, lsb<=0, load pulses on the next cycle.
REQ-009 With RW=11, first write: din goes to a pending low-byte register, the write pointer moves to MSB, and msb/lsb/load SHALL be unchanged.
REQ-010 With RW=11, second write: lsb<=pending, msb<=din in the same edge; load pulses on the next cycle; the write pointer returns to LSB.
REQ-011 load SHALL be exactly one cycle wide; null_count SHALL clear on the same edge that asserts load.
REQ-012 Read (addr=00, rd=1): the source is the latch if latched=1, else cur_count sampled on that edge; dout SHALL update on that edge and hold until the next accepted read.
REQ-013 Read byte selection SHALL be: RW=01 -> low byte; RW=10 -> high byte; RW=11 -> low byte, then high byte, alternating via the read pointer.
REQ-014 A latch SHALL be released (latched=0) after the final byte of one complete read (one read for RW=01/10, two for RW=11); the read pointer then returns to LSB.
REQ-015 Reads with configured=0 SHALL return dout=8'h00 and change no state.
REQ-016 If wr and rd are both asserted in the same cycle, wr SHALL be served and rd ignored.
REQ-017 Accesses to addr=01 or addr=10 SHALL change no state.
REQ-018 Write and read pointers SHALL be independent; an RW=11 write sequence interleaved with reads SHALL not disturb either pointer.
REQ-019 A control word arriving between the two bytes of an RW=11 write SHALL discard the pending byte; msb/lsb SHALL keep their previous values.

Reset
REQ-020 While rst=1, outputs SHALL be: dout=0, msb=0, lsb=0, load=0, mode=000, bcd=0, null_count=0.
REQ-021 While rst=1, internal state SHALL be: configured=0, RW=00, latched=0, latch=0, pending=0, both pointers at LSB.
REQ-022 Reset asserted mid-sequence (pending byte or held latch) SHALL discard that state immediately, without waiting for a clock edge.

Verification
REQ-023 Write ctrl 8'h32 (RW=11, M=001), then writes 8'h34 and 8'h12 -> msb=12, lsb=34, one load pulse after the 2nd write, null_count 1->0, mode=001.
REQ-024 Write ctrl 8'h1C (RW=01, M=110), then write 8'h05 -> lsb=05, msb=00, load pulses, mode=010.
REQ-025 RW=11 configured, cur_count=16'hABCD, latch command (8'h00), cur_count changes to 16'h1111, two reads -> dout=CD then AB; the next two reads -> 11, 11.
REQ-026 Latch command issued twice before reading with cur_count changing between them -> the first captured value is returned.
REQ-027 Control word with SC=01 and count writes before any control word -> no output change and no load pulse.
REQ-028 Assert rst after the first byte of an RW=11 write, then reconfigure and write 8'h01, 8'h00 -> msb=00, lsb=01, with no stale byte.
